key_echo_uart_tx: RTL and testbench
===================================

# key_echo_uart_tx

Serial echo transmitter for the snake controller. It watches the latched direction key and the turbo strobe produced by the keyboard movement driver, queues one ASCII byte per accepted event, and serializes the queue as 8N1 UART frames on the board TX pin. The PC terminal therefore sees the command stream the game actually accepted. It sits between the keyboard movement driver outputs and the top-level `tx` pin, in the same clock domain.

## Interface

- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 4, event queue entries; power of two, 2..16.
- `clk`  input  1  system clock.
- `rst`  input  1  reset, synchronous, active-high.
- `key`  input  8  current accepted direction, ASCII `0x31`..`0x39` excluding `0x35`.
- `turbo_button`  input  1  turbo level from the driver, high while `5` is held.
- `tx`  output  1  UART serial line, idle high.
- `busy`  output  1  high while the FIFO is non-empty or the TX FSM is not IDLE.
- `overflow`  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

## Operation

- Event detection, registered:
  - `key_prev` resets to `0x00`, so the driver's initial LEFT (`0x34`) is echoed once after reset.
  - Key event: `key != key_prev`. `key_prev` updates every cycle.
  - Turbo event: rising edge of `turbo_button`, detected against `turbo_prev`, which resets to 0. The event enqueues `0x35`.
- FIFO write, at most one per cycle:
  - A key event has priority over a turbo event in the same cycle.
  - A concurrent turbo event sets `turbo_pending`, which is written on the next cycle with no key event.
  - `turbo_pending` holds at most one event. A further rising edge while it is set is merged into it, with no overflow.
- Full FIFO:
  - The write is discarded and `overflow` pulses on that cycle.
  - A pending turbo event that finds the FIFO full is also discarded, with `overflow`.
  - No write is accepted while the FIFO is full, even if a pop happens in the same cycle.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- TX FSM states:
  - IDLE: `tx` = 1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: LSB first, 8 bits, each held `CLKS_PER_BIT` cycles. A 3-bit counter counts 0..7, then the FSM goes to STOP.
  - STOP: `tx` = 1 for `CLKS_PER_BIT` cycles, then go to IDLE (or SUFFIX, see Configuration).
- Baud counter: 16-bit, counts 0..`CLKS_PER_BIT`-1, cleared on every state entry.
- `tx` is driven from a register with no combinational path.
- Reset mid-frame:
  - Next edge: `tx` = 1, FSM = IDLE, FIFO emptied, both counters = 0, `key_prev` = 0, `turbo_prev` = 0, `turbo_pending` = 0.
  - A truncated frame is acceptable; no resume.

## Timing

- Reset values: `tx` = 1, `busy` = 0, `overflow` = 0.
- Latency to start bit:
  - `key` changes before edge N.
  - Event is written to the FIFO at edge N+1.
  - IDLE pops at edge N+2, and `tx` falls at edge N+2.
- Frame length: 10 × `CLKS_PER_BIT` cycles from the start-bit edge to the end of the stop bit.
- Inter-frame gap: exactly 1 IDLE cycle (`tx` = 1) between back-to-back frames.
- `busy` is registered. It rises at edge N+1 and falls on the edge where the FSM enters IDLE with the FIFO empty.

## Configuration

- `ECHO_CRLF_EN`
  - Defined: the FSM adds a SUFFIX phase after STOP of each popped byte. SUFFIX sends two full frames, `0x0D` then `0x0A`, each followed by the 1-cycle IDLE gap. Only then is the next FIFO entry popped.
  - With the macro, one event occupies 3 frames plus 3 gap cycles. The FIFO still stores one byte per event.
  - Undefined: SUFFIX logic is absent and exactly one frame is sent per event.

## Test plan

- Reset release, `key` = `0x34`, `CLKS_PER_BIT` = 4 -> `tx` low 2 edges after reset deasserts. Frame `0,0,0,1,0,1,1,0,0,1` over 40 cycles; `busy` falls after it.
- Key `0x34`→`0x38`, then 10 cycles later `0x36` -> two frames, `0x38` then `0x36`, separated by exactly 1 idle cycle; `overflow` stays 0.
- Key change and `turbo_button` rising on the same cycle -> FIFO receives `0x39` and then `0x35` on consecutive cycles; frames are sent in that order.
- Six key changes in 6 consecutive cycles, `FIFO_DEPTH` = 4 -> the first frame is popped 1 cycle after the first write, and 4 entries remain queued. Changes 1–5 are accepted, and `overflow` pulses once on the 6th. Five frames go out in order.
- `rst` asserted at cycle 15 of a frame -> `tx` = 1 and `busy` = 0 next edge, and no further frames follow. With `key` held constant, one frame restarts 2 cycles after deassert, from the `key_prev` reset.
- `ECHO_CRLF_EN` defined, single key `0x32` -> frames `0x32`, `0x0D`, `0x0A`, total 3 × 40 + 3 cycles until `busy` falls.

Source files
------------

// File: rtl/key_echo_uart_tx.sv
// Echoes accepted direction/turbo key events as 8N1 UART frames through a small event FIFO.
// Define ECHO_CRLF_EN to follow every echoed byte with a CR (0x0D) and LF (0x0A) frame.
module key_echo_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] key,
   input  logic       turbo_button,
   output logic       tx,
   output logic       busy,
   output logic       overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3
`ifdef ECHO_CRLF_EN
      , SUFFIX = 3'd4
`endif
   } state_t;

   logic [7:0]    key_prev_r;
   logic          turbo_prev_r;
   logic          key_evt_r;
   logic          turbo_evt_r;
   logic          turbo_pending_r;
   logic [7:0]    mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   state_t        state_r;
   logic [15:0]   baud_r;
   logic [2:0]    bit_r;
   logic [7:0]    shift_r;
   logic          tx_r;
   logic          busy_r;
   logic          overflow_r;
`ifdef ECHO_CRLF_EN
   logic [1:0]    sfx_r;
   logic [1:0]    sfx_s;
`endif

   logic          wr_req_s;
   logic [7:0]    wr_data_s;
   logic          pending_s;
   logic          full_s;
   logic          empty_s;
   logic          wr_en_s;
   logic          pop_s;
   logic [CW-1:0] count_s;
   state_t        state_s;
   logic [15:0]   baud_s;
   logic [2:0]    bit_s;
   logic [7:0]    shift_s;
   logic          tx_s;
   logic          busy_s;

   assign full_s  = (count_r == FULL_CNT);
   assign empty_s = (count_r == {CW{1'b0}});
   assign wr_en_s = wr_req_s & ~full_s;

   // Registered event detection; key_prev_r holds the key that a key event writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_prev_r   <= 8'h00;
         turbo_prev_r <= 1'b0;
         key_evt_r    <= 1'b0;
         turbo_evt_r  <= 1'b0;
      end else begin
         key_prev_r   <= key;
         turbo_prev_r <= turbo_button;
         key_evt_r    <= (key != key_prev_r);
         turbo_evt_r  <= turbo_button & ~turbo_prev_r;
      end
   end

   // Write arbitration: key first, turbo deferred into a single merged pending slot.
   always_comb begin
      wr_req_s  = 1'b0;
      wr_data_s = key_prev_r;
      pending_s = turbo_pending_r;
      if (key_evt_r) begin
         wr_req_s  = 1'b1;
         wr_data_s = key_prev_r;
         if (turbo_evt_r) begin
            pending_s = 1'b1;
         end else begin
            pending_s = turbo_pending_r;
         end
      end else if (turbo_evt_r || turbo_pending_r) begin
         wr_req_s  = 1'b1;
         wr_data_s = 8'h35;
         pending_s = 1'b0;
      end else begin
         wr_req_s  = 1'b0;
      end
   end

   // TX FSM next-state, shift/baud counters and FIFO occupancy.
   always_comb begin
      state_s = state_r;
      baud_s  = baud_r + 16'd1;
      bit_s   = bit_r;
      shift_s = shift_r;
      tx_s    = tx_r;
      pop_s   = 1'b0;
`ifdef ECHO_CRLF_EN
      sfx_s   = sfx_r;
`endif
      case (state_r)
         IDLE: begin
            tx_s   = 1'b1;
            baud_s = 16'd0;
            if (!empty_s) begin
               pop_s   = 1'b1;
               shift_s = mem_r[rd_ptr_r];
               tx_s    = 1'b0;
               state_s = START;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (baud_r == BAUD_LAST) begin
               state_s = DATA;
               baud_s  = 16'd0;
               bit_s   = 3'd0;
               tx_s    = shift_r[0];
            end else begin
               tx_s    = 1'b0;
            end
         end
         DATA: begin
            if (baud_r == BAUD_LAST) begin
               baud_s = 16'd0;
               if (bit_r == 3'd7) begin
                  state_s = STOP;
                  tx_s    = 1'b1;
               end else begin
                  bit_s   = bit_r + 3'd1;
                  shift_s = {1'b0, shift_r[7:1]};
                  tx_s    = shift_r[1];
               end
            end else begin
               tx_s = shift_r[0];
            end
         end
         STOP: begin
            tx_s = 1'b1;
            if (baud_r == BAUD_LAST) begin
               baud_s = 16'd0;
`ifdef ECHO_CRLF_EN
               if (sfx_r == 2'd2) begin
                  state_s = IDLE;
                  sfx_s   = 2'd0;
               end else begin
                  state_s = SUFFIX;
               end
`else
               state_s = IDLE;
`endif
            end else begin
               state_s = STOP;
            end
         end
`ifdef ECHO_CRLF_EN
         SUFFIX: begin
            // One idle-level cycle, then launch CR or LF.
            baud_s  = 16'd0;
            shift_s = (sfx_r == 2'd0) ? 8'h0D : 8'h0A;
            sfx_s   = sfx_r + 2'd1;
            tx_s    = 1'b0;
            state_s = START;
         end
`endif
         default: begin
            state_s = IDLE;
            baud_s  = 16'd0;
            tx_s    = 1'b1;
         end
      endcase

      case ({wr_en_s, pop_s})
         2'b10:   count_s = count_r + CNT_ONE;
         2'b01:   count_s = count_r - CNT_ONE;
         default: count_s = count_r;
      endcase
      busy_s = (count_s != {CW{1'b0}}) || (state_s != IDLE);
   end

   // FIFO storage; emptiness is governed by the reset pointers and count.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= wr_data_s;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         turbo_pending_r <= 1'b0;
         wr_ptr_r        <= {AW{1'b0}};
         rd_ptr_r        <= {AW{1'b0}};
         count_r         <= {CW{1'b0}};
         state_r         <= IDLE;
         baud_r          <= 16'd0;
         bit_r           <= 3'd0;
         shift_r         <= 8'h00;
         tx_r            <= 1'b1;
         busy_r          <= 1'b0;
         overflow_r      <= 1'b0;
`ifdef ECHO_CRLF_EN
         sfx_r           <= 2'd0;
`endif
      end else begin
         turbo_pending_r <= pending_s;
         wr_ptr_r        <= wr_en_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
         rd_ptr_r        <= pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
         count_r         <= count_s;
         state_r         <= state_s;
         baud_r          <= baud_s;
         bit_r           <= bit_s;
         shift_r         <= shift_s;
         tx_r            <= tx_s;
         busy_r          <= busy_s;
         overflow_r      <= wr_req_s & full_s;
`ifdef ECHO_CRLF_EN
         sfx_r           <= sfx_s;
`endif
      end
   end

   assign tx       = tx_r;
   assign busy     = busy_r;
   assign overflow = overflow_r;
endmodule

// File: tb/tb_key_echo_uart_tx.sv
// Directed bench for key_echo_uart_tx (CLKS_PER_BIT = 4, FIFO_DEPTH = 4); outputs are logged per cycle.
module tb_key_echo_uart_tx;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int LOGN  = 1024;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] key;
   logic       turbo_button;
   logic       tx;
   logic       busy;
   logic       overflow;

   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   logic tx_log   [LOGN];
   logic busy_log [LOGN];
   logic ovf_log  [LOGN];

   key_echo_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .key          (key),
      .turbo_button (turbo_button),
      .tx           (tx),
      .busy         (busy),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   // Edge counter: after posedge k, cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   // Log the value each output holds after edge cyc.
   always @(negedge clk) begin
      if (cyc < LOGN) begin
         tx_log[cyc]   <= tx;
         busy_log[cyc] <= busy;
         ovf_log[cyc]  <= overflow;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Compare 10*CPB logged tx cycles starting at edge s against an 8N1 frame of b.
   task automatic check_frame(input string tag, input int s, input logic [7:0] b);
      logic [63:0] obs;
      logic [63:0] exp;
      int          bi;
      obs = 64'd0;
      exp = 64'd0;
      for (int i = 0; i < 10 * CPB; i++) begin
         bi = i / CPB;
         obs[i] = tx_log[s + i];
         if (bi == 0)      exp[i] = 1'b0;
         else if (bi == 9) exp[i] = 1'b1;
         else              exp[i] = b[bi - 1];
      end
      check(tag, obs, exp);
   endtask

   function automatic int count_tx_low(input int a, input int b);
      int n = 0;
      for (int i = a; i < b; i++) if (tx_log[i] !== 1'b1) n++;
      return n;
   endfunction

   function automatic int count_ovf(input int a, input int b);
      int n = 0;
      for (int i = a; i < b; i++) if (ovf_log[i] !== 1'b0) n++;
      return n;
   endfunction

   initial begin
      int k;
      logic [7:0] vals [6];
      vals[0] = 8'h31; vals[1] = 8'h32; vals[2] = 8'h33;
      vals[3] = 8'h34; vals[4] = 8'h36; vals[5] = 8'h37;
      rst          = 1'b1;
      turbo_button = 1'b0;
`ifdef ECHO_CRLF_EN
      key = 8'h32;
`else
      key = 8'h34;
`endif
      step(3);
      check("reset_tx", tx, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_ovf", overflow, 1'b0);

`ifdef ECHO_CRLF_EN
      // Single key 0x32: data frame, CR frame, LF frame, each followed by one idle cycle.
      rst = 1'b0;
      k = cyc;
      step(140);
      check("crlf_busy_pre", busy_log[k+1], 1'b0);
      check("crlf_busy_rise", busy_log[k+2], 1'b1);
      check_frame("crlf_f0", k + 3, 8'h32);
      check("crlf_gap0", tx_log[k+43], 1'b1);
      check_frame("crlf_cr", k + 44, 8'h0D);
      check("crlf_gap1", tx_log[k+84], 1'b1);
      check_frame("crlf_lf", k + 85, 8'h0A);
      check("crlf_busy_last", busy_log[k+124], 1'b1);
      check("crlf_busy_fall", busy_log[k+125], 1'b0);
      check("crlf_quiet", count_tx_low(k + 125, k + 140), 0);
`else
      // Reset release with key 0x34: echoed once from key_prev = 0.
      rst = 1'b0;
      k = cyc;
      step(50);
      check("t1_busy_pre", busy_log[k+1], 1'b0);
      check("t1_busy_rise", busy_log[k+2], 1'b1);
      check("t1_tx_pre", tx_log[k+2], 1'b1);
      check_frame("t1_frame34", k + 3, 8'h34);
      check("t1_busy_last", busy_log[k+42], 1'b1);
      check("t1_busy_fall", busy_log[k+43], 1'b0);

      // 0x38 then 0x36 ten cycles later: back-to-back with one idle cycle.
      key = 8'h38;
      k = cyc;
      step(10);
      key = 8'h36;
      step(100);
      check_frame("t2_frame38", k + 3, 8'h38);
      check("t2_gap", tx_log[k+43], 1'b1);
      check_frame("t2_frame36", k + 44, 8'h36);
      check("t2_busy_fall", busy_log[k+84], 1'b0);
      check("t2_no_ovf", count_ovf(k, k + 110), 0);

      // Key change and turbo rise together: 0x39 first, then 0x35.
      key = 8'h39;
      turbo_button = 1'b1;
      k = cyc;
      step(5);
      turbo_button = 1'b0;
      step(95);
      check_frame("t3_frame39", k + 3, 8'h39);
      check("t3_gap", tx_log[k+43], 1'b1);
      check_frame("t3_frame35", k + 44, 8'h35);
      check("t3_busy_fall", busy_log[k+84], 1'b0);
      check("t3_no_ovf", count_ovf(k, k + 100), 0);

      // Six changes on consecutive cycles: five accepted, sixth overflows.
      k = cyc;
      for (int i = 0; i < 6; i++) begin
         key = vals[i];
         step(1);
      end
      step(230);
      check("t4_ovf_pulse", ovf_log[k+7], 1'b1);
      check("t4_ovf_count", count_ovf(k, k + 236), 1);
      for (int i = 0; i < 5; i++) begin
         check_frame($sformatf("t4_frame%0d", i), k + 3 + 41 * i, vals[i]);
      end
      check("t4_busy_last", busy_log[k+206], 1'b1);
      check("t4_busy_fall", busy_log[k+207], 1'b0);
      check("t4_no_sixth", count_tx_low(k + 207, k + 236), 0);

      // Reset at cycle 15 of a 0x38 frame; restart from key_prev reset.
      key = 8'h38;
      k = cyc;
      step(17);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(100);
      check("t5_tx_before", tx_log[k+17], 1'b0);
      check("t5_busy_before", busy_log[k+17], 1'b1);
      check("t5_tx_reset", tx_log[k+18], 1'b1);
      check("t5_busy_reset", busy_log[k+18], 1'b0);
      check("t5_idle_after", count_tx_low(k + 18, k + 21), 0);
      check_frame("t5_restart38", k + 21, 8'h38);
      check("t5_busy_fall", busy_log[k+61], 1'b0);
      check("t5_quiet", count_tx_low(k + 61, k + 118), 0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
